// File: rtl/ukprom_seq.sv
// ukprom_seq: micro-sequencer that executes 4-bit microcode nibbles fetched from a 1K x 4 synchronous PROM.
// Each nibble costs an RD (address out) and a CAP (data in) cycle; an instruction executes on the edge ending its last CAP.
module ukprom_seq #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [9:0] START_ADR   = 10'h000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [9:0] rom_adr,
  input  logic [3:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       out_we,
  input  logic       ev_req,
  output logic       ev_ack,
  output logic       busy,
  output logic       halted,
  output logic       err
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_CALL = 4'h2;
  localparam logic [3:0] OP_RET  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_DEC  = 4'h8;
  localparam logic [3:0] OP_WAIT = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {IDLE, RD, CAP, WAITEV, HALTED} state_t;

  state_t          state, state_n;
  logic [9:0]      pc, pc_n, pc_inc, rom_adr_n;
  logic [9:0]      ins_adr, ins_adr_n, cur_adr, target;
  logic [3:0]      op, op_n, cur_op, a1, a1_n, acc, acc_n, out_port_n;
  logic [1:0]      a2, a2_n, idx, idx_n;
  logic [SP_W-1:0] sp, sp_n;
  logic [IDX_W-1:0] top_idx, push_idx;
  logic            out_we_n, ev_ack_n, err_n, push, fault;
  logic [9:0]      stack [STACK_DEPTH];

  function automatic logic [1:0] operand_count(input logic [3:0] o);
    case (o)
      OP_JMP, OP_CALL, OP_JZ: return 2'd3;
      OP_LDI:                 return 2'd1;
      default:                return 2'd0;
    endcase
  endfunction

  assign pc_inc   = pc + 10'd1;
  assign cur_op   = (idx == 2'd0) ? rom_data : op;
  assign cur_adr  = (idx == 2'd0) ? pc : ins_adr;
  assign target   = {a2, a1, rom_data};
  assign top_idx  = IDX_W'(sp - 1'b1);
  assign push_idx = IDX_W'(sp);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    rom_adr_n  = rom_adr;
    ins_adr_n  = ins_adr;
    op_n       = op;
    a2_n       = a2;
    a1_n       = a1;
    idx_n      = idx;
    acc_n      = acc;
    sp_n       = sp;
    out_port_n = out_port;
    out_we_n   = 1'b0;
    ev_ack_n   = 1'b0;
    err_n      = err;
    push       = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          pc_n      = START_ADR;
          rom_adr_n = START_ADR;
          sp_n      = '0;
          err_n     = 1'b0;
          idx_n     = 2'd0;
          state_n   = RD;
        end
      end
      RD: state_n = CAP;
      CAP: begin
        pc_n      = pc_inc;
        rom_adr_n = pc_inc;
        state_n   = RD;
        idx_n     = idx + 2'd1;
        case (idx)
          2'd0: begin op_n = rom_data; ins_adr_n = pc; end
          2'd1: a2_n = rom_data[1:0];
          2'd2: a1_n = rom_data;
          default: ;
        endcase
        if (idx == operand_count(cur_op)) begin
          idx_n = 2'd0;
          case (cur_op)
            OP_JMP: begin pc_n = target; rom_adr_n = target; end
            OP_CALL: begin
              if (sp == SP_FULL) fault = 1'b1;
              else begin
                push      = 1'b1;
                sp_n      = sp + 1'b1;
                pc_n      = target;
                rom_adr_n = target;
              end
            end
            OP_RET: begin
              if (sp == '0) fault = 1'b1;
              else begin
                sp_n      = sp - 1'b1;
                pc_n      = stack[top_idx];
                rom_adr_n = stack[top_idx];
              end
            end
            OP_LDI: acc_n = rom_data;
            OP_OUT: begin out_port_n = acc; out_we_n = 1'b1; end
            OP_IN:  acc_n = in_port;
            OP_JZ: begin
              if (acc == 4'h0) begin pc_n = target; rom_adr_n = target; end
            end
            OP_DEC:  acc_n = acc - 4'h1;
            OP_WAIT: begin state_n = WAITEV; rom_adr_n = rom_adr; end
            OP_HALT: begin state_n = HALTED; rom_adr_n = rom_adr; end
            default: ;
          endcase
        end
        // A stack fault parks the sequencer on the offending instruction.
        if (fault) begin
          err_n     = 1'b1;
          state_n   = HALTED;
          pc_n      = cur_adr;
          rom_adr_n = cur_adr;
        end
      end
      WAITEV: begin
        if (ev_req) begin
          ev_ack_n  = 1'b1;
          state_n   = RD;
          rom_adr_n = pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      rom_adr  <= '0;
      ins_adr  <= '0;
      op       <= '0;
      a2       <= '0;
      a1       <= '0;
      idx      <= '0;
      acc      <= '0;
      sp       <= '0;
      out_port <= '0;
      out_we   <= 1'b0;
      ev_ack   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      rom_adr  <= rom_adr_n;
      ins_adr  <= ins_adr_n;
      op       <= op_n;
      a2       <= a2_n;
      a1       <= a1_n;
      idx      <= idx_n;
      acc      <= acc_n;
      sp       <= sp_n;
      out_port <= out_port_n;
      out_we   <= out_we_n;
      ev_ack   <= ev_ack_n;
      err      <= err_n;
    end
  end

  // Return addresses are pure data; sp alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc;
  end

  assign busy   = (state != IDLE) && (state != HALTED);
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_ukprom_seq.sv
// Bench for ukprom_seq: PROM model, instruction-level reference model checked every cycle,
// and directed microcode programs with hand-computed cycle counts and results.
module tb_ukprom_seq;
  localparam int         STACK_DEPTH = 4;
  localparam logic [9:0] START_ADR   = 10'h000;
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ev_req = 1'b0;
  logic [3:0] in_port = 4'h0;
  logic [3:0] rom_data = 4'h0;
  logic [9:0] rom_adr;
  logic [3:0] out_port;
  logic       out_we, ev_ack, busy, halted, err;
  logic [3:0] rom [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ukprom_seq #(.STACK_DEPTH(STACK_DEPTH), .START_ADR(START_ADR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rom_adr(rom_adr), .rom_data(rom_data),
    .in_port(in_port), .out_port(out_port), .out_we(out_we), .ev_req(ev_req), .ev_ack(ev_ack),
    .busy(busy), .halted(halted), .err(err)
  );

  always @(posedge clk) rom_data <= rom[rom_adr];

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  int         m_mode = M_IDLE;
  logic [3:0] m_acc = 4'h0;
  logic [9:0] m_pc = '0, m_ins = '0;
  logic       m_err = 1'b0;
  logic [9:0] stk[$];
  logic [9:0] aq[$];
  logic [9:0] exp_rom_adr = '0;
  logic [3:0] exp_out_port = 4'h0;
  logic       exp_out_we = 1'b0, exp_ev_ack = 1'b0;

  function automatic int nops(input logic [3:0] o);
    case (o)
      4'h1, 4'h2, 4'h7: return 3;
      4'h4:             return 1;
      default:          return 0;
    endcase
  endfunction

  // Every nibble of an instruction shows its address for two cycles.
  task automatic begin_ins(input logic [9:0] a);
    int n;
    n = 1 + nops(rom[a]);
    m_ins = a;
    aq.delete();
    for (int i = 0; i < n; i++) begin
      aq.push_back(10'(a + 10'(i)));
      aq.push_back(10'(a + 10'(i)));
    end
    m_mode = M_RUN;
    exp_rom_adr = aq[0];
  endtask

  task automatic m_fault();
    m_err = 1'b1;
    m_mode = M_HALT;
    exp_rom_adr = m_ins;
    aq.delete();
  endtask

  task automatic m_exec();
    logic [3:0] o, n1, n2, n3;
    logic [9:0] nxt, tgt;
    o   = rom[m_ins];
    n1  = rom[10'(m_ins + 10'd1)];
    n2  = rom[10'(m_ins + 10'd2)];
    n3  = rom[10'(m_ins + 10'd3)];
    nxt = 10'(m_ins + 10'(1 + nops(o)));
    tgt = {n1[1:0], n2, n3};
    case (o)
      4'h1: begin_ins(tgt);
      4'h2: if (stk.size() >= STACK_DEPTH) m_fault(); else begin stk.push_back(nxt); begin_ins(tgt); end
      4'h3: if (stk.size() == 0) m_fault(); else begin_ins(stk.pop_back());
      4'h4: begin m_acc = n1; begin_ins(nxt); end
      4'h5: begin exp_out_port = m_acc; exp_out_we = 1'b1; begin_ins(nxt); end
      4'h6: begin m_acc = in_port; begin_ins(nxt); end
      4'h7: begin_ins((m_acc == 4'h0) ? tgt : nxt);
      4'h8: begin m_acc = m_acc - 4'h1; begin_ins(nxt); end
      4'h9: begin m_pc = nxt; m_mode = M_WAIT; end
      4'hF: m_mode = M_HALT;
      default: begin_ins(nxt);
    endcase
  endtask

  task automatic m_step();
    exp_out_we = 1'b0;
    exp_ev_ack = 1'b0;
    case (m_mode)
      M_IDLE, M_HALT: if (start) begin m_err = 1'b0; stk.delete(); begin_ins(START_ADR); end
      M_RUN: begin
        void'(aq.pop_front());
        if (aq.size() > 0) exp_rom_adr = aq[0];
        else m_exec();
      end
      M_WAIT: if (ev_req) begin exp_ev_ack = 1'b1; begin_ins(m_pc); end
      default: ;
    endcase
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_mode = M_IDLE; m_acc = 4'h0; m_pc = '0; m_err = 1'b0;
        stk.delete(); aq.delete();
        exp_rom_adr = '0; exp_out_port = 4'h0; exp_out_we = 1'b0; exp_ev_ack = 1'b0;
      end else begin
        m_step();
      end
    end
  end

  always @(negedge clk) begin
    check("rom_adr", int'(rom_adr), int'(exp_rom_adr));
    check("out_port", int'(out_port), int'(exp_out_port));
    check("out_we", int'(out_we), int'(exp_out_we));
    check("ev_ack", int'(ev_ack), int'(exp_ev_ack));
    check("busy", int'(busy), (m_mode == M_RUN || m_mode == M_WAIT) ? 1 : 0);
    check("halted", int'(halted), (m_mode == M_HALT) ? 1 : 0);
    check("err", int'(err), int'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 4'hF;
  endtask

  task automatic put(input logic [9:0] a, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) rom[10'(a + 10'(i))] = v[4*(n-1-i) +: 4];
  endtask

  int r_halt, r_we, r_ack, r_nwe, r_nack, r_back, r_max, r_idle;

  // Pulse start, then observe cycle k (after the k-th edge counted from the start edge) until halted.
  task automatic run(input int max, input int ev_at, input int st_at);
    int prev;
    r_halt = -1; r_we = -1; r_ack = -1; r_nwe = 0; r_nack = 0; r_back = 0; r_max = 0; r_idle = 0;
    prev = -1;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (out_we) begin r_nwe++; if (r_we < 0) r_we = k; end
      if (ev_ack) begin r_nack++; if (r_ack < 0) r_ack = k; end
      if (prev >= 0 && int'(rom_adr) < prev) r_back++;
      prev = int'(rom_adr);
      if (int'(rom_adr) > r_max) r_max = int'(rom_adr);
      if (k == ev_at) ev_req = 1'b1;
      start = (k == st_at);
      if (halted) begin r_halt = k; break; end
      if (!busy) r_idle++;
    end
    start = 1'b0;
  endtask

  initial begin
    clear_rom();
    repeat (3) @(posedge clk);
    #2;
    check("rst_rom_adr", int'(rom_adr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_halted", int'(halted), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    // LDI 7, OUT, HALT
    put(10'h000, 16'h475F, 4);
    run(60, -1, -1);
    check("p1_we_cycle", r_we, 6);
    check("p1_we_count", r_nwe, 1);
    check("p1_halt_cycle", r_halt, 8);
    check("p1_out_port", int'(out_port), 7);
    check("p1_busy", int'(busy), 0);

    // LDI 3; JZ 00B; DEC; JMP 002; HALT at 00B
    clear_rom();
    put(10'h000, 16'h4370, 4); put(10'h004, 16'h0B81, 4); put(10'h008, 16'h002F, 4);
    run(200, -1, -1);
    check("loop_back_jumps", r_back, 3);
    check("loop_halt_cycle", r_halt, 68);
    check("loop_max_adr", r_max, 16'h00B);
    check("loop_out_held", int'(out_port), 7);

    // Five nested CALLs: the fifth overflows the stack
    clear_rom();
    put(10'h000, 16'h2100, 4); put(10'h100, 16'h2104, 4); put(10'h104, 16'h2108, 4);
    put(10'h108, 16'h210C, 4); put(10'h10C, 16'h2110, 4);
    run(200, -1, -1);
    check("call5_halt_cycle", r_halt, 40);
    check("call5_err", int'(err), 1);
    check("call5_rom_adr", int'(rom_adr), 16'h10C);

    // CALL 100 / LDI 9 / RET / OUT / HALT, restart clears err
    clear_rom();
    put(10'h000, 16'h2100, 4); put(10'h004, 16'h005F, 2); put(10'h100, 16'h0493, 3);
    run(200, -1, -1);
    check("ret_we_cycle", r_we, 16);
    check("ret_halt_cycle", r_halt, 18);
    check("ret_out_port", int'(out_port), 9);
    check("ret_err", int'(err), 0);

    // RET with empty stack
    clear_rom();
    put(10'h000, 16'h0003, 1);
    run(60, -1, -1);
    check("ret0_halt_cycle", r_halt, 2);
    check("ret0_err", int'(err), 1);

    // IN C, OUT, NOP A, LDI 0, DEC, NOP E, OUT, HALT
    clear_rom();
    in_port = 4'hC;
    put(10'h000, 16'h65A4, 4); put(10'h004, 16'h08E5, 4); put(10'h008, 16'h000F, 1);
    run(100, -1, -1);
    check("in_we_cycle", r_we, 4);
    check("in_we_count", r_nwe, 2);
    check("in_halt_cycle", r_halt, 18);
    check("dec_wrap_out", int'(out_port), 15);

    // WAIT with a late event, start pulse while busy ignored
    clear_rom();
    put(10'h000, 16'h9455, 4); put(10'h004, 16'h000F, 1);
    run(100, 22, 10);
    ev_req = 1'b0;
    check("wait_ack_cycle", r_ack, 23);
    check("wait_ack_count", r_nack, 1);
    check("wait_idle_cycles", r_idle, 0);
    check("wait_halt_cycle", r_halt, 31);
    check("wait_out_port", int'(out_port), 5);

    // WAIT with event already pending
    ev_req = 1'b1;
    run(100, -1, -1);
    ev_req = 1'b0;
    check("waitpre_ack_cycle", r_ack, 3);
    check("waitpre_ack_count", r_nack, 1);
    check("waitpre_halt_cycle", r_halt, 11);

    // Reset during a JMP operand read
    clear_rom();
    put(10'h000, 16'h1234, 4); put(10'h234, 16'h4A5F, 4);
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rom_adr", int'(rom_adr), 1);
    reset_n = 1'b0;
    #1;
    check("arst_rom_adr", int'(rom_adr), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_out_port", int'(out_port), 0);
    check("arst_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", int'(busy), 0);
    run(100, -1, -1);
    check("jmp_we_cycle", r_we, 14);
    check("jmp_halt_cycle", r_halt, 16);
    check("jmp_out_port", int'(out_port), 10);

    // JMP 3FD, then a JMP whose last operand wraps to 000 -> 241
    clear_rom();
    put(10'h000, 16'h13FD, 4); put(10'h3FD, 16'h0124, 3); put(10'h241, 16'h465F, 4);
    run(100, -1, -1);
    check("wrap_max_adr", r_max, 16'h3FF);
    check("wrap_halt_cycle", r_halt, 24);
    check("wrap_out_port", int'(out_port), 6);
    check("wrap_rom_adr", int'(rom_adr), 16'h244);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
